// File: rtl/p2s_seq_ctrl.sv
// Load/shift sequencer for the FFT output parallel-to-serial chain.
// Accepts one NWORDS-word block, then streams it downstream with valid/ready, index and last tags.
module p2s_seq_ctrl #(
    parameter int NWORDS = 8,
    parameter int CW     = 3,
    parameter int FW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic          flush,
    output logic          p2s_ld,
    output logic          p2s_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [CW-1:0] out_idx,
    output logic          busy,
    output logic [FW-1:0] frame_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;

    logic in_shift;
    logic last;
    logic xfer;
    logic accept;

    // All strobes are qualified by rst_n so they drop the instant reset asserts.
    always_comb begin
        in_shift  = rst_n & (state_q == SHIFT);
        last      = (cnt_q == LAST_IDX);
        xfer      = in_shift & out_ready;
        blk_ready = rst_n & ~flush & (~in_shift | (xfer & last));
        accept    = blk_valid & blk_ready;
        p2s_ld    = accept;
        p2s_en    = rst_n & ~flush & (accept | (xfer & ~last));
        out_valid = in_shift;
        busy      = in_shift;
        out_last  = in_shift & last;
        out_idx   = rst_n ? cnt_q : '0;
        frame_cnt = rst_n ? frame_q : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (!last) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            // A reload on the final transfer keeps the chain busy with no bubble.
                            frame_d = frame_q + FW'(1);
                            cnt_d   = '0;
                            state_d = accept ? SHIFT : IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: tb/tb_p2s_seq_ctrl.sv
// Self-checking bench for p2s_seq_ctrl: directed scenarios plus randomized traffic
// compared against a queue-of-pending-words reference model.
module tb_p2s_seq_ctrl;

    localparam int NWORDS = 8;
    localparam int CW     = 3;
    localparam int FW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          blk_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          blk_ready, p2s_ld, p2s_en, out_valid, out_last, busy;
    logic [CW-1:0] out_idx;
    logic [FW-1:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_frames = 0;

    // Reference: the words of the block in flight still waiting to leave, front = current word.
    int ref_q[$];
    int ref_frames = 0;

    always #5 clk = ~clk;

    p2s_seq_ctrl #(.NWORDS(NWORDS), .CW(CW), .FW(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .flush     (flush),
        .p2s_ld    (p2s_ld),
        .p2s_en    (p2s_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // Applies the coming rising edge to the model using the inputs now held, then moves to the next falling edge.
    task automatic advance();
        bit acc;
        if (!rst_n) begin
            ref_q.delete();
            ref_frames = 0;
        end else if (flush) begin
            ref_q.delete();
        end else begin
            acc = blk_valid && (ref_q.size() == 0 || (ref_q.size() == 1 && out_ready));
            if (ref_q.size() > 0 && out_ready) begin
                if (ref_q[0] == NWORDS - 1) ref_frames++;
                void'(ref_q.pop_front());
            end
            if (acc) for (int i = 0; i < NWORDS; i++) ref_q.push_back(i);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; blk_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({blk_ready, p2s_ld, p2s_en, out_valid, out_last, busy, out_idx, frame_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {blk_ready, p2s_ld, p2s_en, out_valid, out_last, busy, out_idx, frame_cnt});
        end
        advance(); advance();
        rst_n = 1'b1; blk_valid = 1'b0; out_ready = 1'b0; #1;
        n_cmp++;
        if ({blk_ready, out_valid, busy, frame_cnt} !== {1'b1, 1'b0, 1'b0, FW'(0)}) begin
            n_bad++;
            $display("FAIL reset_release: got %h required %h", {blk_ready, out_valid, busy, frame_cnt},
                     {1'b1, 1'b0, 1'b0, FW'(0)});
        end
        tb_frames = 0;
    endtask

    task automatic test_single_block();
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        n_cmp++;
        if ({blk_ready, p2s_ld, p2s_en, out_valid} !== 4'b1110) begin
            n_bad++;
            $display("FAIL single_accept: got %b required 1110", {blk_ready, p2s_ld, p2s_en, out_valid});
        end
        for (int i = 0; i < NWORDS; i++) begin
            advance();
            blk_valid = 1'b0; #1;
            n_cmp++;
            if ({out_valid, busy, out_last, p2s_en, p2s_ld, out_idx} !==
                {1'b1, 1'b1, (i == NWORDS - 1), (i < NWORDS - 1), 1'b0, CW'(i)}) begin
                n_bad++;
                $display("FAIL single_word%0d: got %b required %b", i,
                         {out_valid, busy, out_last, p2s_en, p2s_ld, out_idx},
                         {1'b1, 1'b1, (i == NWORDS - 1), (i < NWORDS - 1), 1'b0, CW'(i)});
            end
        end
        advance(); #1;
        tb_frames++;
        n_cmp++;
        if ({out_valid, busy, blk_ready, frame_cnt} !== {1'b0, 1'b0, 1'b1, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL single_done: got %h required %h", {out_valid, busy, blk_ready, frame_cnt},
                     {1'b0, 1'b0, 1'b1, FW'(tb_frames)});
        end
    endtask

    task automatic test_stall();
        int exp_idx;
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        for (int c = 0; c < NWORDS + 3; c++) begin
            advance();
            blk_valid = 1'b0;
            out_ready = !(c >= 4 && c <= 6); #1;
            exp_idx = (c < 4) ? c : ((c <= 7) ? 4 : c - 3);
            n_cmp++;
            if ({out_valid, out_last, p2s_en, out_idx} !==
                {1'b1, (exp_idx == NWORDS - 1), (out_ready && exp_idx < NWORDS - 1), CW'(exp_idx)}) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: got %b required %b", c, {out_valid, out_last, p2s_en, out_idx},
                         {1'b1, (exp_idx == NWORDS - 1), (out_ready && exp_idx < NWORDS - 1), CW'(exp_idx)});
            end
        end
        advance(); #1;
        tb_frames++;
        n_cmp++;
        if ({out_valid, frame_cnt} !== {1'b0, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL stall_done: got %h required %h", {out_valid, frame_cnt}, {1'b0, FW'(tb_frames)});
        end
    endtask

    task automatic test_back_to_back();
        logic e_ld, e_en, e_rdy;
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        for (int c = 0; c < 3 * NWORDS; c++) begin
            advance();
            blk_valid = (c < 2 * NWORDS); #1;
            e_rdy = (c % NWORDS == NWORDS - 1);
            e_ld  = (c == NWORDS - 1) || (c == 2 * NWORDS - 1);
            e_en  = !e_rdy || e_ld;
            n_cmp++;
            if ({out_valid, p2s_ld, p2s_en, blk_ready, out_idx} !==
                {1'b1, e_ld, e_en, e_rdy, CW'(c % NWORDS)}) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d: got %b required %b", c, {out_valid, p2s_ld, p2s_en, blk_ready, out_idx},
                         {1'b1, e_ld, e_en, e_rdy, CW'(c % NWORDS)});
            end
        end
        advance();
        blk_valid = 1'b0; #1;
        tb_frames += 3;
        n_cmp++;
        if ({out_valid, frame_cnt} !== {1'b0, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL b2b_done: got %h required %h", {out_valid, frame_cnt}, {1'b0, FW'(tb_frames)});
        end
    endtask

    task automatic test_flush();
        // Abort at index 3, with a competing block request that must be refused.
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        for (int c = 0; c < 4; c++) begin
            advance();
            blk_valid = (c == 3); flush = (c == 3); #1;
        end
        n_cmp++;
        if ({out_valid, out_idx, blk_ready, p2s_ld, p2s_en} !== {1'b1, CW'(3), 3'b000}) begin
            n_bad++;
            $display("FAIL flush_strobes: got %b required %b", {out_valid, out_idx, blk_ready, p2s_ld, p2s_en},
                     {1'b1, CW'(3), 3'b000});
        end
        advance();
        flush = 1'b0; blk_valid = 1'b0; #1;
        n_cmp++;
        if ({out_valid, busy, blk_ready, frame_cnt} !== {1'b0, 1'b0, 1'b1, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL flush_idle: got %h required %h", {out_valid, busy, blk_ready, frame_cnt},
                     {1'b0, 1'b0, 1'b1, FW'(tb_frames)});
        end
        // Abort coinciding with the final transfer must not count a frame.
        blk_valid = 1'b1; #1;
        for (int c = 0; c < NWORDS; c++) begin
            advance();
            blk_valid = 1'b0; flush = (c == NWORDS - 1); #1;
        end
        n_cmp++;
        if ({out_last, p2s_en, blk_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL flush_last_strobes: got %b required 100", {out_last, p2s_en, blk_ready});
        end
        advance();
        flush = 1'b0; #1;
        n_cmp++;
        if ({out_valid, frame_cnt} !== {1'b0, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL flush_last_count: got %h required %h", {out_valid, frame_cnt}, {1'b0, FW'(tb_frames)});
        end
        blk_valid = 1'b1; #1;
        for (int c = 0; c < NWORDS; c++) begin
            advance();
            blk_valid = 1'b0; #1;
        end
        advance(); #1;
        tb_frames++;
        n_cmp++;
        if ({out_valid, frame_cnt} !== {1'b0, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL flush_recover: got %h required %h", {out_valid, frame_cnt}, {1'b0, FW'(tb_frames)});
        end
    endtask

    task automatic test_reset_mid();
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        for (int c = 0; c < 6; c++) begin
            advance();
            blk_valid = 1'b0; #1;
        end
        n_cmp++;
        if ({out_valid, out_idx} !== {1'b1, CW'(5)}) begin
            n_bad++;
            $display("FAIL rstmid_pre: got %b required %b", {out_valid, out_idx}, {1'b1, CW'(5)});
        end
        blk_valid = 1'b1; rst_n = 1'b0; #1;
        n_cmp++;
        if ({blk_ready, p2s_ld, p2s_en, out_valid, out_last, busy, out_idx, frame_cnt} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %h required 0",
                     {blk_ready, p2s_ld, p2s_en, out_valid, out_last, busy, out_idx, frame_cnt});
        end
        advance();
        advance();
        rst_n = 1'b1; blk_valid = 1'b0; #1;
        tb_frames = 0;
        n_cmp++;
        if ({blk_ready, out_valid, frame_cnt} !== {1'b1, 1'b0, FW'(0)}) begin
            n_bad++;
            $display("FAIL rstmid_release: got %h required %h", {blk_ready, out_valid, frame_cnt},
                     {1'b1, 1'b0, FW'(0)});
        end
    endtask

    task automatic test_wrap();
        localparam int NBLK = 1 << FW;
        logic e_ld;
        advance();
        blk_valid = 1'b1; out_ready = 1'b1; #1;
        for (int c = 0; c < NBLK * NWORDS; c++) begin
            advance();
            blk_valid = (c < (NBLK - 1) * NWORDS); #1;
            e_ld = (c % NWORDS == NWORDS - 1) && (c < (NBLK - 1) * NWORDS);
            n_cmp++;
            if ({out_valid, p2s_ld, blk_ready, out_idx, frame_cnt} !==
                {1'b1, e_ld, (c % NWORDS == NWORDS - 1), CW'(c % NWORDS), FW'(tb_frames + c / NWORDS)}) begin
                n_bad++;
                $display("FAIL wrap_cycle%0d: got %h required %h", c, {out_valid, p2s_ld, blk_ready, out_idx, frame_cnt},
                         {1'b1, e_ld, (c % NWORDS == NWORDS - 1), CW'(c % NWORDS), FW'(tb_frames + c / NWORDS)});
            end
        end
        advance();
        blk_valid = 1'b0; #1;
        tb_frames += NBLK;
        n_cmp++;
        if ({out_valid, frame_cnt} !== {1'b0, FW'(tb_frames)}) begin
            n_bad++;
            $display("FAIL wrap_done: got %h required %h", {out_valid, frame_cnt}, {1'b0, FW'(tb_frames)});
        end
    endtask

    task automatic test_random();
        logic          e_valid, e_last, e_rdy, e_ld, e_en;
        logic [CW-1:0] e_idx;
        for (int c = 0; c < 800; c++) begin
            advance();
            blk_valid = ($urandom_range(0, 99) < 50);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            #1;
            e_valid = (ref_q.size() > 0);
            e_idx   = '0;
            e_last  = 1'b0;
            if (e_valid) begin
                e_idx  = CW'(ref_q[0]);
                e_last = (ref_q[0] == NWORDS - 1);
            end
            e_rdy = !flush && (ref_q.size() == 0 || (ref_q.size() == 1 && out_ready));
            e_ld  = blk_valid && e_rdy;
            e_en  = !flush && (e_ld || (ref_q.size() > 1 && out_ready));
            n_cmp++;
            if ({out_valid, busy, out_last, out_idx} !== {e_valid, e_valid, e_last, e_idx}) begin
                n_bad++;
                $display("FAIL rand_stream%0d: got %b required %b", c, {out_valid, busy, out_last, out_idx},
                         {e_valid, e_valid, e_last, e_idx});
            end
            n_cmp++;
            if ({blk_ready, p2s_ld, p2s_en} !== {e_rdy, e_ld, e_en}) begin
                n_bad++;
                $display("FAIL rand_strobes%0d: got %b required %b", c, {blk_ready, p2s_ld, p2s_en},
                         {e_rdy, e_ld, e_en});
            end
            n_cmp++;
            if (frame_cnt !== FW'(ref_frames)) begin
                n_bad++;
                $display("FAIL rand_frames%0d: got %0d required %0d", c, frame_cnt, FW'(ref_frames));
            end
        end
        flush = 1'b0; blk_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
